// File: rtl/mem_port_arbiter3_if.sv
`default_nettype none
// ============================================================================
// Module      : mem_port_arbiter3_if
// Description : Requester and memory-side signal bundle for mem_port_arbiter3.
// Revision    : 1.0 - initial release
// ============================================================================
interface mem_port_arbiter3_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic [2:0]          req;
    logic [3*ADDR_W-1:0] addr_in;
    logic [3*DATA_W-1:0] wdata_in;
    logic [2:0]          we_in;
    logic [2:0]          grant;
    logic [2:0]          ack;
    logic                err;
    logic [DATA_W-1:0]   rdata;
    logic [1:0]          select;
    logic                mem_en;
    logic                mem_we;
    logic [ADDR_W-1:0]   mem_addr;
    logic [DATA_W-1:0]   mem_wdata;
    logic                mem_ready;
    logic [DATA_W-1:0]   mem_rdata;

    // Arbiter side
    modport slave (
        input  req, addr_in, wdata_in, we_in, mem_ready, mem_rdata,
        output grant, ack, err, rdata, select,
        output mem_en, mem_we, mem_addr, mem_wdata
    );

    // Requesters plus memory side
    modport master (
        output req, addr_in, wdata_in, we_in, mem_ready, mem_rdata,
        input  grant, ack, err, rdata, select,
        input  mem_en, mem_we, mem_addr, mem_wdata
    );
endinterface
`default_nettype wire

// File: rtl/mem_port_arbiter3.sv
`default_nettype none
// ============================================================================
// Module      : mem_port_arbiter3
// Description : Round-robin arbiter for the shared memory port of the
//               multicycle core (fetch, load/store, debug/DMA).
// Revision    : 1.0 - initial release
// ============================================================================
module mem_port_arbiter3 #(
    parameter int ADDR_W   = 32,
    parameter int DATA_W   = 32,
    parameter int MAX_WAIT = 15
) (
    input  wire logic          clk,
    input  wire logic          reset,
    mem_port_arbiter3_if.slave bus
);
    localparam int                 c_CNT_W     = $clog2(MAX_WAIT + 1);
    localparam logic [c_CNT_W-1:0] c_WAIT_LAST = c_CNT_W'(MAX_WAIT - 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCESS = 2'd1,
        S_RESP   = 2'd2
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [1:0]          r_ptr;
    logic [c_CNT_W-1:0]  r_wait;
    logic [1:0]          r_select;
    logic [2:0]          r_grant;
    logic [ADDR_W-1:0]   r_addr;
    logic [DATA_W-1:0]   r_wdata;
    logic                r_we;
    logic [DATA_W-1:0]   r_rdata;
    logic                r_err;

    logic                w_win_valid;
    logic [1:0]          w_win;
    logic [ADDR_W-1:0]   w_win_addr;
    logic [DATA_W-1:0]   w_win_wdata;
    logic                w_win_we;
    logic                w_timeout;

    function automatic logic [1:0] f_rot(input logic [1:0] base, input int off);
        int s;
        s = int'(base) + off;
        return 2'(s % 3);
    endfunction

    // Scan from the farthest position back to ptr so the nearest requester wins.
    always_comb begin
        w_win_valid = 1'b0;
        w_win       = 2'd0;
        for (int i = 2; i >= 0; i--) begin
            if (bus.req[f_rot(r_ptr, i)]) begin
                w_win_valid = 1'b1;
                w_win       = f_rot(r_ptr, i);
            end
        end
    end

    always_comb begin
        w_win_addr  = bus.addr_in[0 +: ADDR_W];
        w_win_wdata = bus.wdata_in[0 +: DATA_W];
        w_win_we    = bus.we_in[0];
        case (w_win)
            2'd1: begin
                w_win_addr  = bus.addr_in[ADDR_W +: ADDR_W];
                w_win_wdata = bus.wdata_in[DATA_W +: DATA_W];
                w_win_we    = bus.we_in[1];
            end
            2'd2: begin
                w_win_addr  = bus.addr_in[2*ADDR_W +: ADDR_W];
                w_win_wdata = bus.wdata_in[2*DATA_W +: DATA_W];
                w_win_we    = bus.we_in[2];
            end
            default: ;
        endcase
    end

    // Next-state: a ready response beats a coincident timeout.
    always_comb begin
        w_state_nxt = r_state;
        w_timeout   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_win_valid) begin
                    w_state_nxt = S_ACCESS;
                end
            end
            S_ACCESS: begin
                if (bus.mem_ready) begin
                    w_state_nxt = S_RESP;
                end else if (r_wait == c_WAIT_LAST) begin
                    w_timeout   = 1'b1;
                    w_state_nxt = S_RESP;
                end
            end
            S_RESP: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_ptr    <= 2'd0;
            r_wait   <= '0;
            r_select <= 2'd0;
            r_grant  <= 3'b000;
            r_addr   <= '0;
            r_wdata  <= '0;
            r_we     <= 1'b0;
            r_rdata  <= '0;
            r_err    <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_win_valid) begin
                        r_select <= w_win;
                        r_grant  <= 3'b001 << w_win;
                        r_addr   <= w_win_addr;
                        r_wdata  <= w_win_wdata;
                        r_we     <= w_win_we;
                        r_wait   <= '0;
                    end
                end
                S_ACCESS: begin
                    if (bus.mem_ready) begin
                        r_rdata <= r_we ? '0 : bus.mem_rdata;
                        r_err   <= 1'b0;
                    end else if (w_timeout) begin
                        r_rdata <= '0;
                        r_err   <= 1'b1;
                    end else begin
                        r_wait  <= r_wait + 1'b1;
                    end
                end
                S_RESP: begin
                    r_ptr   <= (r_select == 2'd2) ? 2'd0 : r_select + 2'd1;
                    r_grant <= 3'b000;
                    r_err   <= 1'b0;
                    r_wait  <= '0;
                end
                default: ;
            endcase
        end
    end

    // Strobes derive from state so an asynchronous reset removes them at once.
    assign bus.mem_en    = (r_state == S_ACCESS);
    assign bus.mem_we    = (r_state == S_ACCESS) & r_we;
    assign bus.mem_addr  = r_addr;
    assign bus.mem_wdata = r_wdata;
    assign bus.grant     = r_grant;
    assign bus.ack       = (r_state == S_RESP) ? r_grant : 3'b000;
    assign bus.err       = r_err;
    assign bus.rdata     = r_rdata;
    assign bus.select    = r_select;

endmodule
`default_nettype wire

// File: doc/mem_port_arbiter3.md
Name: mem_port_arbiter3

Overview:
- Round-robin arbiter that shares the single unified memory port of the multicycle MIPS core between three requesters: 0 = instruction fetch, 1 = load/store unit, 2 = debug/DMA loader.
- Sequences each transaction and drives the 2-bit select of the 3:1 address/data mux in front of memory.
- Returns read data, a one-cycle acknowledge and a timeout error to the winning requester.

Parameters:
- ADDR_W, 32, address width per requester.
- DATA_W, 32, data width.
- MAX_WAIT, 15, maximum ACCESS cycles without mem_ready before abort; must be ≥1.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- req  in  3  request per requester; held high until its ack.
- addr_in  in  3*ADDR_W  requester k address at bits [k*ADDR_W +: ADDR_W].
- wdata_in  in  3*DATA_W  requester k write data, packed the same way.
- we_in  in  3  write enable per requester.
- grant  out  3  one-hot owner of the memory port; 0 when idle.
- ack  out  3  one-hot, one-cycle completion pulse.
- err  out  1  valid with ack; 1 = timeout abort.
- rdata  out  DATA_W  read data, valid with ack.
- select  out  2  mux select: 0, 1 or 2; 3 is never driven.
- mem_en  out  1  memory access strobe.
- mem_we  out  1  memory write.
- mem_addr  out  ADDR_W  memory address.
- mem_wdata  out  DATA_W  memory write data.
- mem_ready  in  1  memory completes the access this cycle.
- mem_rdata  in  DATA_W  memory read data, valid with mem_ready.

Behaviour:
- Reset (async, immediate):
  - state = IDLE, ptr = 0, wait counter = 0.
  - All outputs = 0, including select.
  - Reset during ACCESS or RESP drops mem_en and grant immediately; no ack or err is issued.
- States: IDLE, ACCESS, RESP.
- IDLE:
  - grant = 0, mem_en = 0; select holds its last value.
  - When req ≠ 0, choose winner k as the first requester with req high in the order ptr, ptr+1, ptr+2 (mod 3).
  - At the clock edge: latch addr/wdata/we of k, set select = k and grant = one-hot(k), clear the wait counter, go to ACCESS.
- ACCESS:
  - mem_en = 1; mem_addr, mem_wdata and mem_we come from the latched copies, not live inputs.
  - grant is held.
  - If mem_ready = 1: rdata ← mem_rdata (0 for writes), err ← 0, go to RESP.
  - Else if wait counter = MAX_WAIT−1: rdata ← 0, err ← 1, go to RESP.
  - Else increment the wait counter.
  - mem_ready wins over a coincident timeout.
- RESP:
  - ack = one-hot(k) for exactly one cycle; grant held; mem_en = 0.
  - At the edge: ptr ← (k+1) mod 3, go to IDLE, clear ack, err and grant.
  - rdata holds its value until the next RESP.
- Timing:
  - Request in IDLE cycle 0 → grant and mem_en in cycle 1.
  - Earliest ack in cycle 2 when mem_ready is high in cycle 1.
  - Minimum 3 cycles per transaction; a continuously held req is re-arbitrated in IDLE as a new request.
- Inputs are sampled only in IDLE. req changes during ACCESS or RESP have no effect on the current transaction.
- A requester dropping req before ack does not abort the transaction; the ack is still issued.
- Wait counter width is $clog2(MAX_WAIT+1). It never wraps, because leaving ACCESS clears it.
- mem_en is never high outside ACCESS. grant, ack and select are always consistent with the latched k.

Test Plan:
1. Single read: req = 001, addr_0 = 0x00000040, we = 0, mem_ready high in the 2nd ACCESS cycle with mem_rdata = 0xFF44FF44 → select = 0, mem_addr = 0x40, grant = 001 for 3 cycles, ack = 001 one cycle, rdata = 0xFF44FF44, err = 0.
2. Fairness: req = 111 held, mem_ready tied 1 → grants 001, 010, 100, 001 on successive 3-cycle transactions; select sequence 0, 1, 2, 0.
3. Write: req = 100, addr_2 = 0x100, wdata_2 = 0x33AA44FF, we_in = 100; change addr_2 mid-ACCESS → mem_we = 1, mem_addr stays 0x100, mem_wdata = 0x33AA44FF, select = 2, ack = 100.
4. Timeout: MAX_WAIT = 4, mem_ready = 0 → ack after 4 ACCESS cycles with err = 1, rdata = 0. A subsequent req = 010 completes normally with err = 0.
5. Ready at the timeout boundary: MAX_WAIT = 4, mem_ready = 1 in the 4th ACCESS cycle with mem_rdata = 0x00000001 → err = 0, rdata = 0x00000001.
6. Reset mid-ACCESS: assert reset between edges → mem_en, grant and select go to 0 without waiting for a clock edge, no ack. After release with req = 110, requester 1 wins because ptr = 0.
